bcd_a_binario_seq: RTL and testbench
====================================

Name: bcd_a_binario_seq

Overview:
- Sequential BCD-to-binary encoder: the reverse of the clock's binary-to-BCD/7-segment display path.
- Accepts a packed multi-digit BCD value, for example a time field entered digit-by-digit from switches or a keypad.
- Converts it to binary with one multiply-by-10-and-add step per clock, so the value can be preloaded into the up/down counter.
- Uses a start/busy/done handshake and flags invalid BCD digits.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in (digit DIGITS-1 is the most significant).
- OUT, 6, width of bin_out; matches the counter width.
- MAX_VAL, 59, largest legal result; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD; bits [3:0] are units, bits [7:4] are tens, and so on.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when a result is written.
- err  out  1  last conversion contained a digit greater than 9.
- ovf  out  1  last result exceeded the representable or legal range.
- bin_out  out  OUT  binary result, held between conversions.

Behaviour:
- Reset (asynchronous, rst_n low), effective immediately:
  - State goes to IDLE.
  - busy=0, done=0, err=0, ovf=0, bin_out=0.
  - Internal accumulator and digit index are cleared.
- State machine, one state register: IDLE, CONV.
- IDLE:
  - done is 0 except during the single pulse cycle.
  - If start=1 at a rising edge: latch bcd_in into a shadow register, clear acc (4*DIGITS bits wide), set idx=DIGITS-1, clear an internal bad-digit flag, set busy=1, go to CONV.
- CONV, one digit per edge, most significant digit first:
  - acc <= acc*10 + digit[idx]; implement *10 as (acc<<3)+(acc<<1).
  - If digit[idx] > 9, set the bad-digit flag.
  - Decrement idx each edge.
  - On the edge that processes idx=0:
    - Write the result (see below).
    - err <= bad flag; ovf updated as described below.
    - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: with the start edge as edge 0, done and the new bin_out appear after edge DIGITS; busy is high for exactly DIGITS cycles.
- Result write:
  - If the bad flag is set: bin_out keeps its previous value, err=1, ovf=0.
  - Otherwise, if acc > 2^OUT-1: ovf=1 and bin_out = acc[OUT-1:0] (truncated).
  - Otherwise: bin_out=acc, err=0, ovf=0.
- err and ovf are sticky only until the next done; they are updated at every completion.
- start while busy=1 is ignored and not queued. start held high continuously re-triggers on the first IDLE edge after done, giving back-to-back conversions every DIGITS+1 cycles.
- Changes to bcd_in during CONV have no effect because the value is shadow-latched.
- Reset mid-conversion aborts it: no done pulse, and bin_out returns to 0.
- Digit values A–F are processed arithmetically (the accumulation continues) but the result is discarded via err.

Optional Feature:
- Macro: BCD_A_BINARIO_RANGE_CHK_EN.
- Defined:
  - Any valid result with acc > MAX_VAL sets ovf=1, and bin_out is clamped to MAX_VAL.
  - This check replaces the 2^OUT-1 truncation rule.
  - MAX_VAL must be ≤ 2^OUT-1.
- Not defined: MAX_VAL is unused, and only the 2^OUT-1 truncation rule applies.

Test Plan:
- Reset then idle, no start -> busy=0, done=0, err=0, ovf=0, bin_out=0 for 20 cycles.
- bcd_in=8'h47, start pulse -> busy high 2 cycles, done pulse 2 cycles after the start edge, bin_out=47 (6'b101111), err=0, ovf=0.
- bcd_in=8'h3C (units digit 12), start -> done, err=1, ovf=0, bin_out still 47 from the previous run; next run with 8'h05 -> bin_out=5, err=0.
- bcd_in=8'h99 with the macro undefined -> ovf=1, bin_out=99 mod 64=35. With the macro defined, bcd_in=8'h72 -> ovf=1, bin_out=59. With the macro defined, bcd_in=8'h59 -> ovf=0, bin_out=59.
- Start pulse asserted in the busy cycle after a first start with bcd_in changed to 8'h11 -> only one done; result matches the first latched value (8'h23 -> 23).
- rst_n driven low in the cycle after start (bcd_in=8'h30) -> outputs return to 0 immediately, no done pulse; after release, a new conversion of 8'h12 gives bin_out=12.

Source files
------------

// File: rtl/bcd_a_binario_seq.sv
// Sequential packed-BCD to binary encoder, one digit per clock, MSD first.
// Optional macro BCD_A_BINARIO_RANGE_CHK_EN clamps valid results to MAX_VAL.
module bcd_a_binario_seq #(
    parameter int DIGITS  = 2,
    parameter int OUT     = 6,
    parameter int MAX_VAL = 59
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ovf,
    output logic [OUT-1:0]        bin_out
);

    localparam int AW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] LIMIT = (64'd1 << OUT) - 64'd1;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   shadow_q, shadow_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            bad_q, bad_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic [OUT-1:0]  bin_q, bin_d;

    logic [3:0]      digit;
    logic            digit_bad;
    logic            bad_final;
    logic [AW-1:0]   acc_step;
    logic [63:0]     acc_ext;

    // Digit currently addressed by idx; shift-and-add avoids a multiplier.
    assign digit     = shadow_q[{idx_q, 2'b00} +: 4];
    assign digit_bad = (digit > 4'd9);
    assign bad_final = bad_q | digit_bad;
    assign acc_step  = (acc_q << 3) + (acc_q << 1) + AW'(digit);
    assign acc_ext   = 64'(acc_step);

    always_comb begin
        // NOTE: every signal gets its default before the case so no latch is inferred.
        state_d  = state_q;
        shadow_d = shadow_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        bad_d    = bad_q;
        done_d   = 1'b0;
        err_d    = err_q;
        ovf_d    = ovf_q;
        bin_d    = bin_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = bcd_in;
                    acc_d    = '0;
                    idx_d    = IW'(DIGITS - 1);
                    bad_d    = 1'b0;
                    state_d  = CONV;
                end
            end

            CONV: begin
                acc_d = acc_step;
                bad_d = bad_final;
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (bad_final) begin
                        // Invalid digit: previous result stays visible.
                        err_d = 1'b1;
                        ovf_d = 1'b0;
                    end else begin
                        err_d = 1'b0;
`ifdef BCD_A_BINARIO_RANGE_CHK_EN
                        if (acc_ext > 64'(MAX_VAL)) begin
                            ovf_d = 1'b1;
                            bin_d = OUT'(MAX_VAL);
                        end else begin
                            ovf_d = 1'b0;
                            bin_d = acc_ext[OUT-1:0];
                        end
`else
                        ovf_d = (acc_ext > LIMIT);
                        bin_d = acc_ext[OUT-1:0];
`endif
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            bad_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            bin_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q  <= state_d;
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            bad_q    <= bad_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            bin_q    <= bin_d;
        end
    end

    assign busy    = (state_q == CONV);
    assign done    = done_q;
    assign err     = err_q;
    assign ovf     = ovf_q;
    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_a_binario_seq.sv
// Directed bench for bcd_a_binario_seq with a queue scoreboard of expected results.
// Expectations follow BCD_A_BINARIO_RANGE_CHK_EN when it is defined.
module tb_bcd_a_binario_seq;

    localparam int DIGITS = 2;
    localparam int OUT    = 6;

    typedef struct packed {
        logic [OUT-1:0] bin;
        logic           err;
        logic           ovf;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic                busy;
    logic                done;
    logic                err;
    logic                ovf;
    logic [OUT-1:0]      bin_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [OUT-1:0] last_bin;

    bcd_a_binario_seq #(.DIGITS(DIGITS), .OUT(OUT), .MAX_VAL(59)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .ovf     (ovf),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model of one completed conversion.
    function automatic exp_t model(input logic [7:0] bcd, input logic [OUT-1:0] prev);
        int hi;
        int lo;
        int v;
        exp_t e;
        hi = int'(bcd[7:4]);
        lo = int'(bcd[3:0]);
        v  = hi * 10 + lo;
        if (hi > 9 || lo > 9) begin
            e.bin = prev; e.err = 1'b1; e.ovf = 1'b0;
        end else begin
            e.err = 1'b0;
`ifdef BCD_A_BINARIO_RANGE_CHK_EN
            if (v > 59) begin e.bin = 6'd59;   e.ovf = 1'b1; end
            else        begin e.bin = OUT'(v); e.ovf = 1'b0; end
`else
            e.bin = OUT'(v % 64);
            e.ovf = (v > 63);
`endif
        end
        return e;
    endfunction

    task automatic push(input logic [7:0] bcd);
        exp_t e;
        e = model(bcd, last_bin);
        sb.push_back(e);
        last_bin = e.bin;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_bin"}, 32'(bin_out), 32'(e.bin));
            check({tag, "_err"}, 32'(err), 32'(e.err));
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        end
    endtask

    // Single start pulse; checks latency, busy length and the scoreboard result.
    task automatic run_conv(input logic [7:0] bcd, input string tag);
        int lat;
        int busy_cnt;
        logic seen;
        push(bcd);
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                @(negedge clk);
                lat++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(lat), 32'(DIGITS));
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DIGITS));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            pop_check(tag);
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        bcd_in   = '0;
        last_bin = '0;

        // Idle after reset: all outputs low for 20 cycles.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {busy, done, err, ovf, bin_out}, 32'd0);
        end

        run_conv(8'h47, "conv47");
        run_conv(8'h3C, "bad_digit");
        run_conv(8'h05, "conv05");
        run_conv(8'h99, "conv99");
        run_conv(8'h72, "conv72");
        run_conv(8'h59, "conv59");
        run_conv(8'h00, "conv00");

        // Start repeated while busy with new bcd_in: ignored, original value converted.
        push(8'h23);
        @(negedge clk);
        bcd_in = 8'h23;
        start  = 1'b1;
        @(negedge clk);
        bcd_in = 8'h11;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                done_cnt++;
                pop_check("busy_start");
            end
            @(negedge clk);
        end
        check("busy_start_done_count", 32'(done_cnt), 32'd1);

        // Start held high: back-to-back conversions every DIGITS+1 cycles.
        push(8'h15);
        push(8'h15);
        @(negedge clk);
        bcd_in      = 8'h15;
        start       = 1'b1;
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == DIGITS + 1) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
                else second_done = k;
                pop_check("b2b");
            end
        end
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        check("b2b_first_edge", 32'(first_done), 32'(DIGITS));
        check("b2b_period", 32'(second_done - first_done), 32'(DIGITS + 1));

        // Reset during conversion: immediate clear, no done.
        @(negedge clk);
        bcd_in = 8'h30;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {busy, done, err, ovf, bin_out}, 32'd0);
        last_bin = '0;
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_bin_zero", 32'(bin_out), 32'd0);

        run_conv(8'h12, "after_abort");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
